imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_csum.sv | 37 +++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and defaults for the boot-time
// instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int          DEF_MEM_BYTES = 256;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0;
  localparam int          HDR_LEN       = 2;

  function automatic logic len_too_big(
    input logic [15:0] len,
    input logic [31:0] lim
  );
    return {16'h0, len} > lim;
  endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// imem_loader_csum: 8-bit modulo-256 payload accumulator with
// synchronous clear and a checksum-closes-to-zero test.
module imem_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  input  logic [7:0] chk_i,
  output logic       ok_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic [7:0] tot;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign tot  = sum_q + chk_i;
  assign ok_o = (tot == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, checksummed byte frame
// and writes it into instruction memory while holding the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_BYTES = DEF_MEM_BYTES,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] MEM_LIM = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        acc;
  logic        sum_clr;
  logic        sum_add;
  logic        sum_ok;
  logic [15:0] len_full;

  assign in_ready = (state_q == ST_LEN_LO) ||
                    (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   ||
                    (state_q == ST_CSUM);
  assign acc      = in_valid && in_ready;
  assign len_full = {in_data, len_q[7:0]};

  imem_loader_csum u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (sum_clr),
    .add_i  (sum_add),
    .data_i (in_data),
    .chk_i  (in_data),
    .ok_o   (sum_ok)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sum_clr = 1'b0;
    sum_add = 1'b0;
    unique case (state_q)
      ST_LEN_LO: begin
        if (acc) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (acc) begin
          len_d = len_full;
          if (len_too_big(len_full, MEM_LIM)) begin
            state_d = ST_ERR;
          end else if (len_full == 16'h0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + {16'h0, cnt_q};
          wdata_d = in_data;
          sum_add = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (acc) begin
          state_d = sum_ok ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          cnt_d   = 16'h0;
          len_d   = 16'h0;
          sum_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_LEN_LO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LEN_LO;
      len_q   <= 16'h0;
      cnt_q   <= 16'h0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames checked against a
// frame-level reference model of the loader.
module tb_imem_loader;

  localparam int          MEM  = 256;
  localparam logic [31:0] BASE = 32'h40;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks;
  int errors;

  logic [7:0] frame_q[$];

  imem_loader #(
    .MEM_BYTES (MEM),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic make_frame(input int len, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(len));
    frame_q.push_back(8'(len >> 8));
    s = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      s = s + b;
      frame_q.push_back(b);
    end
    b = 8'h00 - s;
    if (bad) b = b ^ 8'($urandom_range(1, 255));
    frame_q.push_back(b);
  endtask

  // Walks frame_q through the DUT and predicts writes and final status.
  task automatic run_frame(input int max_gap, input bit poke_start);
    int         len;
    int         k;
    int         g;
    bit         over;
    bit         wr;
    logic [7:0] s;
    logic [7:0] tot;
    logic [31:0] ea;
    bit         exp_done;
    len = 0; k = 0; over = 0; s = 8'h00;
    for (int i = 0; i < frame_q.size(); i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL frame_ready byte %0d: got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = frame_q[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (i == 0) len = int'(frame_q[0]);
      if (i == 1) begin
        len  = len + (int'(frame_q[1]) << 8);
        over = (len > MEM);
      end
      wr = !over && (i >= 2) && (i - 2 < len);
      checks++;
      if (mem_we !== wr) begin
        errors++;
        $display("FAIL frame_we byte %0d: got %b want %b", i, mem_we, wr);
      end
      if (wr) begin
        ea = BASE + 32'(k);
        checks++;
        if (mem_addr !== ea || mem_wdata !== frame_q[i]) begin
          errors++;
          $display("FAIL frame_wr k=%0d: got %h/%h want %h/%h",
                   k, mem_addr, mem_wdata, ea, frame_q[i]);
        end
        s = s + frame_q[i];
        k++;
      end
      if (over) break;
      if (i == frame_q.size() - 1) break;
      g = $urandom_range(0, max_gap);
      for (int j = 0; j < g; j++) begin
        if (poke_start) start = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (mem_we !== 1'b0) begin
          errors++;
          $display("FAIL gap_we byte %0d: got %b want 0", i, mem_we);
        end
      end
    end
    exp_done = 1'b0;
    if (!over) begin
      tot = s + frame_q[2 + len];
      exp_done = (tot == 8'h00);
    end
    checks++;
    if (done !== exp_done || error !== !exp_done ||
        cpu_hold !== !exp_done || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: got d=%b e=%b h=%b r=%b want d=%b e=%b h=%b r=0",
               done, error, cpu_hold, in_ready,
               exp_done, !exp_done, !exp_done);
    end
  endtask

  task automatic rearm();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 ||
        error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rearm: got h=%b d=%b e=%b r=%b want 1 0 0 1",
               cpu_hold, done, error, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 8'h00 || cpu_hold !== 1'b1 ||
        done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset: got r=%b we=%b a=%h d=%h h=%b dn=%b e=%b",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed_ok();
    frame_q = '{8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED};
    run_frame(0, 1'b0);
  endtask

  task automatic test_idle_done();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b0 || done !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_done: got we=%b d=%b r=%b want 0 1 0",
                 mem_we, done, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    rearm();
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(2, 1'b0);
  endtask

  task automatic test_bad_csum();
    rearm();
    frame_q = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'h00};
    run_frame(0, 1'b0);
  endtask

  task automatic test_oversize();
    rearm();
    frame_q = '{8'h01, 8'h01};
    run_frame(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b0 || error !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL oversize_hold: got we=%b e=%b r=%b want 0 1 0",
                 mem_we, error, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] part[$];
    rearm();
    part = '{8'h04, 8'h00, 8'h5A, 8'hC3};
    foreach (part[i]) begin
      in_valid = 1'b1;
      in_data  = part[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== BASE + 32'd1) begin
      errors++;
      $display("FAIL mid_write: got we=%b a=%h want 1 %h",
               mem_we, mem_addr, BASE + 32'd1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || in_ready !== 1'b1 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got we=%b a=%h r=%b h=%b d=%b e=%b",
               mem_we, mem_addr, in_ready, cpu_hold, done, error);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    make_frame(5, 1'b0);
    run_frame(1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      rearm();
      make_frame($urandom_range(0, 24), $urandom_range(0, 3) == 0);
      run_frame(3, 1'b1);
    end
  endtask

  task automatic test_max_len();
    rearm();
    make_frame(MEM, 1'b0);
    run_frame(0, 1'b0);
    rearm();
    make_frame(MEM + 1, 1'b0);
    run_frame(0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed_ok();
    test_idle_done();
    test_zero_len();
    test_bad_csum();
    test_oversize();
    test_reset_mid();
    test_random();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
